// File: rtl/life_pkg.sv
// Shared types and defaults for the life-grid pattern loading path.
package life_pkg;

  localparam int ROW_W    = 128;
  localparam int ROM_AW   = 10;
  localparam int DEF_ROWS = 128;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic is_busy(input state_t s);
    return (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/pattern_loader.sv
// Copies one ROWS-row pattern from the pattern ROM into the grid memory, one row per handshake.
// Optional zero-fill loads are enabled with the PATTERN_LOADER_CLEAR_EN macro.
module pattern_loader
  import life_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int WIDTH = ROW_W,
  parameter int AW    = ROM_AW,
  parameter int PSW   = 3
) (
  input  logic                     clka,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [PSW-1:0]           pat_sel,
  output logic [AW-1:0]            rom_addr,
  output logic                     rom_we,
  input  logic [WIDTH-1:0]         rom_dout,
  output logic                     grid_we,
  output logic [$clog2(ROWS)-1:0]  grid_row,
  output logic [WIDTH-1:0]         grid_data,
  input  logic                     grid_ready,
  output logic                     busy,
  output logic                     done
`ifdef PATTERN_LOADER_CLEAR_EN
  ,
  input  logic                     clear
`endif
);

  localparam int RW = $clog2(ROWS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  state_t           state_r, state_n;
  logic [RW-1:0]    row_r, row_n, row_inc_s;
  logic [AW-1:0]    base_r, base_n, base_s;
  logic [AW-1:0]    addr_r, addr_n;
  logic [WIDTH-1:0] buf_r, buf_n;
  logic             clear_r, clear_n, clear_s;
  logic             we_r, busy_r, done_r;

`ifdef PATTERN_LOADER_CLEAR_EN
  assign clear_s = clear;
`else
  assign clear_s = 1'b0;
`endif

  // Pattern base is pat_sel*ROWS folded into the ROM address space
  assign base_s    = AW'(pat_sel) << RW;
  assign row_inc_s = row_r + RW'(1'b1);

  // Next-state and datapath update
  always_comb begin
    state_n = state_r;
    row_n   = row_r;
    base_n  = base_r;
    clear_n = clear_r;
    addr_n  = addr_r;
    buf_n   = buf_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          base_n  = base_s;
          clear_n = clear_s;
          row_n   = {RW{1'b0}};
          if (clear_s) begin
            buf_n   = {WIDTH{1'b0}};
            state_n = ST_WRITE;
          end else begin
            addr_n  = base_s;
            state_n = ST_FETCH;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_n = ST_LATCH;
      end
      ST_LATCH: begin
        buf_n   = rom_dout;
        state_n = ST_WRITE;
      end
      ST_WRITE: begin
        if (grid_ready) begin
          if (row_r == LAST_ROW) begin
            state_n = ST_DONE;
          end else begin
            row_n = row_inc_s;
            // Zero-fill loads never touch the ROM, so the address stays frozen
            if (clear_r) begin
              state_n = ST_WRITE;
            end else begin
              addr_n  = base_r + AW'(row_inc_s);
              state_n = ST_FETCH;
            end
          end
        end else begin
          state_n = ST_WRITE;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      row_r   <= {RW{1'b0}};
      base_r  <= {AW{1'b0}};
      addr_r  <= {AW{1'b0}};
      buf_r   <= {WIDTH{1'b0}};
      clear_r <= 1'b0;
      we_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      row_r   <= row_n;
      base_r  <= base_n;
      addr_r  <= addr_n;
      buf_r   <= buf_n;
      clear_r <= clear_n;
      we_r    <= (state_n == ST_WRITE);
      busy_r  <= is_busy(state_n);
      done_r  <= (state_n == ST_DONE);
    end
  end

  assign rom_addr  = addr_r;
  assign rom_we    = 1'b0;
  assign grid_we   = we_r;
  assign grid_row  = row_r;
  assign grid_data = buf_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_pattern_loader.sv
// Self-checking bench for pattern_loader: table of loads plus hand-written corner sequences.
module tb_pattern_loader;

  localparam int ROWS  = 128;
  localparam int WIDTH = 128;
  localparam int AW    = 10;
  localparam int PSW   = 4;

  logic             clka;
  logic             rst_n;
  logic             start;
  logic [PSW-1:0]   pat_sel;
  logic [AW-1:0]    rom_addr;
  logic             rom_we;
  logic [WIDTH-1:0] rom_dout;
  logic             grid_we;
  logic [6:0]       grid_row;
  logic [WIDTH-1:0] grid_data;
  logic             grid_ready;
  logic             busy;
  logic             done;
`ifdef PATTERN_LOADER_CLEAR_EN
  logic             clear_drv;
`endif

  pattern_loader #(.ROWS(ROWS), .WIDTH(WIDTH), .AW(AW), .PSW(PSW)) dut (
    .clka       (clka),
    .rst_n      (rst_n),
    .start      (start),
    .pat_sel    (pat_sel),
    .rom_addr   (rom_addr),
    .rom_we     (rom_we),
    .rom_dout   (rom_dout),
    .grid_we    (grid_we),
    .grid_row   (grid_row),
    .grid_data  (grid_data),
    .grid_ready (grid_ready),
    .busy       (busy),
    .done       (done)
`ifdef PATTERN_LOADER_CLEAR_EN
    ,
    .clear      (clear_drv)
`endif
  );

  typedef struct {
    logic [6:0]   row;
    logic [127:0] data;
  } row_t;

  typedef struct {
    logic [3:0] pat;
    int         srow;
    int         slen;
    int         lat;
    int         lo;
  } vec_t;

  row_t exp_q[$];
  vec_t vecs[4];
  int   checks    = 0;
  int   failures  = 0;
  int   done_cnt  = 0;
  int   addr_bad  = 0;
  int   lo_addr   = 0;
  int   hi_addr   = 1023;
  int   lat;

  initial begin
    clka = 1'b0;
    forever #5 clka = ~clka;
  end

  function automatic logic [127:0] rom_val(input logic [9:0] a);
    logic [31:0] x;
    logic [31:0] w;
    x = {22'd0, a};
    w = x * 32'h9E37_79B1;
    return {w, ~w, w ^ 32'hA5A5_5A5A, x};
  endfunction

  // Synchronous-read pattern ROM model
  always @(posedge clka) rom_dout <= rom_val(rom_addr);

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every offered grid row is checked, accepted rows are popped
  always @(negedge clka) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (busy && ((int'(rom_addr) < lo_addr) || (int'(rom_addr) > hi_addr))) addr_bad++;
      if (grid_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=row %0d required=no write", grid_row);
        end else begin
          chk("grid_row", {121'd0, grid_row}, {121'd0, exp_q[0].row});
          chk("grid_data", grid_data, exp_q[0].data);
          if (grid_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic push_rows(input logic [3:0] pat, input bit clr);
    row_t e;
    for (int r = 0; r < ROWS; r++) begin
      e.row  = 7'(r);
      e.data = clr ? 128'd0 : rom_val(10'(int'(pat) * ROWS + r));
      exp_q.push_back(e);
    end
  endtask

  task automatic run_load(input logic [3:0] pat, input int srow, input int slen,
                          input int inj_at, input logic [3:0] inj_pat, input bit clr,
                          output int lat_o);
    int n;
    int scnt;
    push_rows(pat, clr);
    done_cnt = 0;
    addr_bad = 0;
    @(negedge clka);
    pat_sel    = pat;
    start      = 1'b1;
    grid_ready = 1'b1;
`ifdef PATTERN_LOADER_CLEAR_EN
    clear_drv  = clr;
`endif
    n     = 0;
    scnt  = 0;
    lat_o = -1;
    while (n < 2000) begin
      @(posedge clka);
      n++;
      #1;
      if (n == 1) start = 1'b0;
      if (n == inj_at) begin
        start   = 1'b1;
        pat_sel = inj_pat;
      end else if (n == inj_at + 1) begin
        start   = 1'b0;
        pat_sel = pat;
      end
      if (grid_we && (int'(grid_row) == srow) && (scnt < slen)) begin
        grid_ready = 1'b0;
        scnt++;
      end else begin
        grid_ready = 1'b1;
      end
      if (done) begin
        lat_o = n;
        break;
      end
    end
    grid_ready = 1'b1;
`ifdef PATTERN_LOADER_CLEAR_EN
    clear_drv  = 1'b0;
`endif
  endtask

  task automatic post_checks(input string name, input int exp_lat, input int lat_i, input bit start_in_done);
    chk({name, "_latency"}, 128'(lat_i), 128'(exp_lat));
    if (start_in_done) begin
      start   = 1'b1;
      pat_sel = 4'd5;
    end
    @(posedge clka);
    #1;
    start = 1'b0;
    chk({name, "_busy_after"}, {127'd0, busy}, 128'd0);
    chk({name, "_done_after"}, {127'd0, done}, 128'd0);
    @(negedge clka);
    chk({name, "_done_count"}, 128'(done_cnt), 128'd1);
    chk({name, "_rows_left"}, 128'(exp_q.size()), 128'd0);
    chk({name, "_addr_range"}, 128'(addr_bad), 128'd0);
  endtask

  initial begin
    int n;
    vecs[0] = '{pat: 4'd2, srow: -1,  slen: 0, lat: 385, lo: 256};
    vecs[1] = '{pat: 4'd3, srow: 10,  slen: 5, lat: 390, lo: 384};
    vecs[2] = '{pat: 4'd8, srow: -1,  slen: 0, lat: 385, lo: 0};
    vecs[3] = '{pat: 4'd7, srow: 127, slen: 2, lat: 387, lo: 896};

    rst_n      = 1'b0;
    start      = 1'b0;
    pat_sel    = 4'd0;
    grid_ready = 1'b1;
`ifdef PATTERN_LOADER_CLEAR_EN
    clear_drv  = 1'b0;
`endif
    #12;
    chk("rst_rom_addr", {118'd0, rom_addr}, 128'd0);
    chk("rst_grid_we", {127'd0, grid_we}, 128'd0);
    chk("rst_grid_row", {121'd0, grid_row}, 128'd0);
    chk("rst_grid_data", grid_data, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_done", {127'd0, done}, 128'd0);
    @(negedge clka);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      lo_addr = vecs[i].lo;
      hi_addr = vecs[i].lo + ROWS - 1;
      run_load(vecs[i].pat, vecs[i].srow, vecs[i].slen, -1, 4'd0, 1'b0, lat);
      post_checks($sformatf("vec%0d", i), vecs[i].lat, lat, 1'b0);
    end

    // Start pulses mid-load and in DONE must be ignored
    lo_addr = 128;
    hi_addr = 255;
    run_load(4'd1, -1, 0, 50, 4'd5, 1'b0, lat);
    post_checks("busy_start", 385, lat, 1'b1);

    // Reset while row 40 is being offered
    lo_addr = 512;
    hi_addr = 639;
    push_rows(4'd4, 1'b0);
    done_cnt = 0;
    @(negedge clka);
    pat_sel = 4'd4;
    start   = 1'b1;
    @(posedge clka);
    #1;
    start = 1'b0;
    n = 0;
    while (!(grid_we && (grid_row == 7'd40)) && (n < 1000)) begin
      @(posedge clka);
      #1;
      n++;
    end
    chk("reach_row40", {127'd0, (n < 1000)}, 128'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_rom_addr", {118'd0, rom_addr}, 128'd0);
    chk("midrst_grid_we", {127'd0, grid_we}, 128'd0);
    chk("midrst_grid_row", {121'd0, grid_row}, 128'd0);
    chk("midrst_grid_data", grid_data, 128'd0);
    chk("midrst_busy", {127'd0, busy}, 128'd0);
    chk("midrst_done", {127'd0, done}, 128'd0);
    repeat (3) @(negedge clka);
    rst_n = 1'b1;
    exp_q.delete();
    @(posedge clka);
    #1;
    chk("release_idle", {127'd0, busy}, 128'd0);
    chk("midrst_no_done", 128'(done_cnt), 128'd0);

    lo_addr = 256;
    hi_addr = 383;
    run_load(4'd2, -1, 0, -1, 4'd0, 1'b0, lat);
    post_checks("after_reset", 385, lat, 1'b0);

`ifdef PATTERN_LOADER_CLEAR_EN
    // Zero-fill load keeps the address from the previous load (256+127)
    lo_addr = 383;
    hi_addr = 383;
    run_load(4'd2, -1, 0, -1, 4'd0, 1'b1, lat);
    post_checks("clear_load", 129, lat, 1'b0);
    chk("clear_rom_addr", {118'd0, rom_addr}, 128'd383);
`endif

    chk("rom_we", {127'd0, rom_we}, 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pattern_loader.md
PATTERN_LOADER -- requirements
Module: pattern_loader

Interface
REQ-001 SHALL have parameter ROWS, default 128: rows per pattern, power of two.
REQ-002 SHALL have parameter WIDTH, default 128: bits per row, equal to the pattern ROM data width.
REQ-003 SHALL have parameter AW, default 10: pattern ROM address width.
REQ-004 SHALL have parameter PSW, default 3: pattern-select width.
REQ-005 SHALL have one clock and an asynchronous, active-low reset; the ports are clka and rst_n.
REQ-006 SHALL have port clka, input, 1: clock shared with the pattern ROM.
REQ-007 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1: load request, sampled only in IDLE.
REQ-009 SHALL have port pat_sel, input, PSW: pattern index, latched on an accepted start.
REQ-010 SHALL have port rom_addr, output, AW: pattern ROM address, registered.
REQ-011 SHALL have port rom_we, output, 1: ROM write enable, constant 0.
REQ-012 SHALL have port rom_dout, input, WIDTH: ROM read data, 1-cycle latency.
REQ-013 SHALL have port grid_we, output, 1: row write valid to the grid memory.
REQ-014 SHALL have port grid_row, output, log2(ROWS): destination row index.
REQ-015 SHALL have port grid_data, output, WIDTH: row contents.
REQ-016 SHALL have port grid_ready, input, 1: the grid accepts a write on an edge where grid_we and grid_ready are both 1.
REQ-017 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-018 SHALL have port done, output, 1: one-cycle pulse on completion.

Function
REQ-019 SHALL implement the states IDLE, FETCH, LATCH, WRITE and DONE.
REQ-020 SHALL, in IDLE with start=1, latch pat_sel, clear the row counter, drive rom_addr=(pat_sel*ROWS) mod 2^AW and go to FETCH.
REQ-021 SHALL go from FETCH to LATCH unconditionally; this is the ROM latency cycle.
REQ-022 SHALL, in LATCH, capture rom_dout into the row buffer, then go to WRITE.
REQ-023 SHALL, in WRITE, hold grid_we=1, with grid_row equal to the row counter and grid_data equal to the row buffer, stable until accepted.
REQ-024 SHALL, on acceptance of a row that is not the last, increment the row counter, set rom_addr to base+row (wrapping mod 2^AW) and go to FETCH.
REQ-025 SHALL, on acceptance of row ROWS-1, go to DONE.
REQ-026 SHALL, in DONE, drive done=1 for exactly one cycle, then go to IDLE.
REQ-027 SHALL give a start-to-done latency of 3*ROWS+1 edges with grid_ready held at 1; each stall cycle adds exactly one cycle.
REQ-028 SHALL ignore start in every state other than IDLE, including DONE; pat_sel changes while busy SHALL have no effect.

Reset
REQ-029 SHALL, with rst_n=0, immediately and asynchronously force IDLE, with rom_addr=0, grid_we=0, grid_row=0, grid_data=0, busy=0, done=0, row counter=0 and row buffer=0.
REQ-030 SHALL, when reset occurs mid-load, abandon the load with no done pulse; the first edge after release SHALL be in IDLE.

Configuration
REQ-031 SHALL, with PATTERN_LOADER_CLEAR_EN defined, add an input port clear (1 bit) latched on an accepted start.
REQ-032 SHALL, when clear is latched as 1, bypass FETCH and LATCH, writing all ROWS rows as zero data from WRITE, with latency ROWS+1 edges and rom_addr frozen.
REQ-033 SHALL, without PATTERN_LOADER_CLEAR_EN, have no clear port and make every load a ROM load.

Structure
REQ-034 SHALL take the state enum, ROW_W=128, ROM_AW=10 and the default ROWS from the shared package life_pkg.
REQ-035 SHALL be a single module with no sub-module.

Verification
REQ-036 SHALL check a basic load: pat_sel=2, start pulse, grid_ready=1 -> rom_addr 256..383 in order, 128 grid writes of rows 0..127 with data equal to ROM[256+r], and done after exactly 385 edges.
REQ-037 SHALL check backpressure: grid_ready low for 5 cycles on row 10 -> grid_we, grid_row and grid_data held stable, no duplicate or skipped row, and done 5 cycles later.
REQ-038 SHALL check start while busy: start pulse with pat_sel=5 during the pat_sel=1 load -> ignored, all addresses stay in 128..255, and exactly one done.
REQ-039 SHALL check reset mid-load: rst_n=0 during row 40 -> all outputs 0 asynchronously and no done; a fresh start then loads from row 0.
REQ-040 SHALL check wrap-around: PSW=4, pat_sel=8, ROWS=128, AW=10 -> rom_addr wraps to 0..127.
REQ-041 SHALL, with PATTERN_LOADER_CLEAR_EN defined, check a clear load: start with clear=1 -> 128 zero rows, rom_addr unchanged, and done after 129 edges.
